// File: rtl/audio_pkg.sv
// Shared constants and parameter legality helpers for the serial audio transmitter.
package audio_pkg;

  // Frame format selector values as seen on the mode input.
  localparam logic AUDIO_MODE_DSP = 1'b0;
  localparam logic AUDIO_MODE_I2S = 1'b1;

  // 12 MHz / 251 gives a sample rate close to 48 kHz.
  localparam int AUDIO_FRAME_DIV_48K = 251;

  function automatic bit audio_sample_w_ok(input int sample_w);
    return (sample_w >= 8) && (sample_w <= 32);
  endfunction

  function automatic bit audio_channels_ok(input int channels);
    return (channels == 1) || (channels == 2);
  endfunction

  // Mode is selected at run time, so the frame must fit both formats.
  function automatic bit audio_frame_div_ok(input int sample_w, input int channels,
                                            input int frame_div);
    return (frame_div >= channels * sample_w + 1) && ((frame_div / 2) >= sample_w + 1);
  endfunction

endpackage

// File: rtl/audio_frame_timer.sv
// Frame position counter: decides load, bit slots, frame pulse and word select.
module audio_frame_timer
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = 32,
  parameter int CHANNELS  = 2,
  parameter int FRAME_DIV = AUDIO_FRAME_DIV_48K
) (
  input  logic clock_12Mhz,
  input  logic reset_n,
  input  logic mode,
  output logic load,
  output logic shift_en,
  output logic frame_start,
  output logic audio_lrck
);

  localparam int POS_W = $clog2(FRAME_DIV);
  localparam int HALF  = FRAME_DIV / 2;

  localparam logic [POS_W-1:0] POS_LAST  = POS_W'(FRAME_DIV - 1);
  localparam logic [POS_W-1:0] POS_HALF  = POS_W'(HALF);
  localparam logic [POS_W-1:0] DSP_END   = POS_W'(CHANNELS * SAMPLE_W);
  localparam logic [POS_W-1:0] LEFT_END  = POS_W'(SAMPLE_W);
  localparam logic [POS_W-1:0] RIGHT_BEG = POS_W'(HALF + 1);
  localparam logic [POS_W-1:0] RIGHT_END = POS_W'(HALF + SAMPLE_W);

  logic [POS_W-1:0] pos_reg;
  logic [POS_W-1:0] pos_next;
  logic             mode_reg;
  logic             mode_next;
  logic             lrck_next;

  // Next position and the slot decode for it; outputs always describe the new pos.
  always_comb begin
    load      = (pos_reg == POS_LAST);
    pos_next  = load ? '0 : pos_reg + 1'b1;
    // The frame being entered uses the mode captured at its own load edge.
    mode_next = load ? mode : mode_reg;
    if (mode_next == AUDIO_MODE_I2S) begin
      shift_en  = ((pos_next != '0) && (pos_next <= LEFT_END)) ||
                  ((CHANNELS == 2) && (pos_next >= RIGHT_BEG) && (pos_next <= RIGHT_END));
      lrck_next = (pos_next >= POS_HALF);
    end else begin
      shift_en  = (pos_next != '0) && (pos_next <= DSP_END);
      lrck_next = (pos_next == '0);
    end
  end

  // Position counter plus registered frame pulse and word select.
  always_ff @(negedge clock_12Mhz or negedge reset_n) begin
    if (!reset_n) begin
      pos_reg     <= POS_LAST;
      mode_reg    <= AUDIO_MODE_DSP;
      frame_start <= 1'b0;
      audio_lrck  <= 1'b0;
    end else begin
      pos_reg     <= pos_next;
      mode_reg    <= mode_next;
      frame_start <= (pos_next == '0);
      audio_lrck  <= lrck_next;
    end
  end

endmodule

// File: rtl/audio_serializer_tx.sv
// Serial audio transmitter: sample holding register, MSB-first shifter, underrun flag.
module audio_serializer_tx
  import audio_pkg::*;
#(
  parameter int SAMPLE_W  = 32,
  parameter int CHANNELS  = 2,
  parameter int FRAME_DIV = AUDIO_FRAME_DIV_48K
) (
  input  logic                         clock_12Mhz,
  input  logic                         reset_n,
  input  logic                         mode,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         underrun_clr,
  output logic                         audio_lrck,
  output logic                         audio_data,
  output logic                         frame_start,
  output logic                         underrun
);

  localparam int WORD_W = CHANNELS * SAMPLE_W;

  if (!audio_sample_w_ok(SAMPLE_W)) begin : g_bad_sample_w
    $error("audio_serializer_tx: SAMPLE_W must be within 8..32");
  end
  if (!audio_channels_ok(CHANNELS)) begin : g_bad_channels
    $error("audio_serializer_tx: CHANNELS must be 1 or 2");
  end
  if (!audio_frame_div_ok(SAMPLE_W, CHANNELS, FRAME_DIV)) begin : g_bad_frame_div
    $error("audio_serializer_tx: FRAME_DIV too small for DSP or I2S framing");
  end

  logic [WORD_W-1:0] hold_reg;
  logic              hold_full_reg;
  logic [WORD_W-1:0] shift_reg;
  logic              first_load_reg;
  logic              load;
  logic              shift_en;
  logic              accept;

  assign sample_ready = !hold_full_reg;
  assign accept       = sample_valid && !hold_full_reg;

  audio_frame_timer #(
    .SAMPLE_W  (SAMPLE_W),
    .CHANNELS  (CHANNELS),
    .FRAME_DIV (FRAME_DIV)
  ) u_timer (
    .clock_12Mhz (clock_12Mhz),
    .reset_n     (reset_n),
    .mode        (mode),
    .load        (load),
    .shift_en    (shift_en),
    .frame_start (frame_start),
    .audio_lrck  (audio_lrck)
  );

  // Single-entry holding register; emptied by the frame load, filled by a handshake.
  always_ff @(negedge clock_12Mhz or negedge reset_n) begin
    if (!reset_n) begin
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else if (load && hold_full_reg) begin
      hold_full_reg <= 1'b0;
    end else if (accept) begin
      hold_reg      <= sample_data;
      hold_full_reg <= 1'b1;
    end
  end

  // Shift register: loaded at frame start, shifted out MSB first in active slots.
  always_ff @(negedge clock_12Mhz or negedge reset_n) begin
    if (!reset_n) begin
      shift_reg  <= '0;
      audio_data <= 1'b0;
    end else if (load) begin
      shift_reg  <= hold_full_reg ? hold_reg : '0;
      audio_data <= 1'b0;
    end else if (shift_en) begin
      shift_reg  <= {shift_reg[WORD_W-2:0], 1'b0};
      audio_data <= shift_reg[WORD_W-1];
    end else begin
      audio_data <= 1'b0;
    end
  end

  // Sticky underrun; the load straight after reset is exempt, and set beats clear.
  always_ff @(negedge clock_12Mhz or negedge reset_n) begin
    if (!reset_n) begin
      first_load_reg <= 1'b1;
      underrun       <= 1'b0;
    end else begin
      if (load) begin
        first_load_reg <= 1'b0;
      end
      if (load && !hold_full_reg && !first_load_reg) begin
        underrun <= 1'b1;
      end else if (underrun_clr) begin
        underrun <= 1'b0;
      end
    end
  end

endmodule
